// File: rtl/sumador_sat_acc.sv
// Pipelined saturating signed add/sub with per-channel saturating accumulators.
// Two registered stages; accumulators update at acceptance so chains never stall.
module sumador_sat_acc #(
    parameter int W    = 32,
    parameter int CH_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [CH_W-1:0] ch,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [CH_W-1:0] out_ch,
    output logic            out_sat,
    input  logic            clr_ovf,
    output logic            ovf_sticky
);

    localparam int CH = 1 << CH_W;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_LD  = 2'b11
    } op_e;

    function automatic logic [W:0] sext(input logic [W-1:0] x);
        return {x[W-1], x};
    endfunction

    function automatic logic ovf(input logic [W:0] r);
        return r[W] ^ r[W-1];
    endfunction

    function automatic logic [W-1:0] clamp(input logic [W:0] r);
        if (!ovf(r))
            return r[W-1:0];
        else if (r[W])
            return {1'b1, {(W-1){1'b0}}};
        else
            return {1'b0, {(W-1){1'b1}}};
    endfunction

    logic [W-1:0]    acc_q [CH];
    logic            s1_valid_q;
    logic [W:0]      s1_sum_q;
    logic [CH_W-1:0] s1_ch_q;
    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic [CH_W-1:0] out_ch_q;
    logic            out_sat_q;
    logic            ovf_q;

    logic            stall;
    logic            accept;
    logic [W:0]      raw_d;
    logic [W-1:0]    acc_d;
    logic            acc_we;
    logic            s2_load;
    logic            s2_sat_d;

    always_comb begin
        stall    = out_valid_q & ~out_ready;
        in_ready = ~stall & ~reset;
        accept   = in_valid & in_ready;
        raw_d    = '0;
        unique case (op_e'(op))
            OP_ADD: raw_d = sext(a) + sext(b);
            OP_SUB: raw_d = sext(a) - sext(b);
            OP_ACC: raw_d = sext(acc_q[ch]) + sext(a);
            OP_LD:  raw_d = sext(a);
            default: raw_d = '0;
        endcase
        // Accumulator takes the clamped value now, so the next beat sees it.
        acc_d    = clamp(raw_d);
        acc_we   = accept & op[1];
        s2_load  = ~stall & s1_valid_q;
        s2_sat_d = ovf(s1_sum_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) acc_q[i] <= '0;
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_ch_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_sat_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (acc_we) acc_q[ch] <= acc_d;
            if (!stall) begin
                s1_valid_q  <= accept;
                out_valid_q <= s1_valid_q;
                if (accept) begin
                    s1_sum_q <= raw_d;
                    s1_ch_q  <= ch;
                end
            end
            if (s2_load) begin
                out_data_q <= clamp(s1_sum_q);
                out_ch_q   <= s1_ch_q;
                out_sat_q  <= s2_sat_d;
            end
            if (s2_load && s2_sat_d)
                ovf_q <= 1'b1;
            else if (clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign out_sat    = out_sat_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_sumador_sat_acc.sv
// Bench for sumador_sat_acc: directed cases plus random stream vs. a
// transaction-level model (queue of expected results, integer accumulators).
module tb_sumador_sat_acc;

    localparam int W    = 32;
    localparam int CH_W = 2;
    localparam int CH   = 4;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      op = '0;
    logic [CH_W-1:0] ch = '0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    out_data;
    logic [CH_W-1:0] out_ch;
    logic            out_sat;
    logic            clr_ovf = 1'b0;
    logic            ovf_sticky;

    always #5 clk = ~clk;

    sumador_sat_acc #(.W(W), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .ch(ch), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .out_sat(out_sat),
        .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky)
    );

    typedef struct {
        logic [W-1:0]    d;
        logic [CH_W-1:0] c;
        logic            s;
    } exp_t;

    exp_t   q[$];
    longint macc[CH];
    int     nchecks = 0;
    int     nerr = 0;
    bit     held = 0;
    logic [W-1:0]    h_d;
    logic [CH_W-1:0] h_c;
    logic            h_s;
    bit     dummy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [CH_W-1:0] c,
                                   input logic [W-1:0] aa, input logic [W-1:0] bb);
        longint sa = longint'($signed(aa));
        longint sb = longint'($signed(bb));
        longint r;
        exp_t e;
        case (o)
            2'd0: r = sa + sb;
            2'd1: r = sa - sb;
            2'd2: r = macc[c] + sa;
            default: r = sa;
        endcase
        e.c = c;
        if (r > MAXV) begin
            e.d = 32'h7FFFFFFF; e.s = 1'b1;
        end else if (r < MINV) begin
            e.d = 32'h80000000; e.s = 1'b1;
        end else begin
            e.d = r[31:0]; e.s = 1'b0;
        end
        if (o[1]) macc[c] = longint'($signed(e.d));
        return e;
    endfunction

    task automatic step(input bit v, input logic [1:0] o, input logic [CH_W-1:0] c,
                        input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input bit ordy, input bit clr, input bit rst, output bit accd);
        exp_t e;
        in_valid = v; op = o; ch = c; a = aa; b = bb;
        out_ready = ordy; clr_ovf = clr; reset = rst;
        #1;
        chk("in_ready", in_ready, !rst && !(out_valid && !ordy));
        if (held) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, h_d);
            chk("hold_ch", out_ch, h_c);
            chk("hold_sat", out_sat, h_s);
            held = 0;
        end
        if (out_valid && ordy) begin
            chk("result_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_ch", out_ch, e.c);
                chk("out_sat", out_sat, e.s);
            end
        end
        if (out_valid && !ordy && !rst) begin
            held = 1; h_d = out_data; h_c = out_ch; h_s = out_sat;
        end
        accd = v && in_ready;
        if (rst) begin
            q.delete();
            for (int i = 0; i < CH; i++) macc[i] = 0;
            held = 0;
        end else if (accd) begin
            q.push_back(model(o, c, aa, bb));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit clr = 0);
        step(0, 2'd0, '0, '0, '0, 1, clr, 0, dummy);
    endtask

    task automatic beat(input logic [1:0] o, input logic [CH_W-1:0] c,
                        input logic [W-1:0] aa, input logic [W-1:0] bb, input bit clr = 0);
        step(1, o, c, aa, bb, 1, clr, 0, dummy);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 3))
            0: return 32'h7FFFFFFF - $urandom_range(0, 3);
            1: return 32'h80000000 + $urandom_range(0, 3);
            2: return $urandom_range(0, 20) - 10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        int tries;
        bit acc;
        bit saw_stall;
        for (int i = 0; i < CH; i++) macc[i] = 0;

        step(0, 2'd0, '0, '0, '0, 1, 0, 1, dummy);
        step(0, 2'd0, '0, '0, '0, 1, 0, 1, dummy);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_ovf", ovf_sticky, 0);

        beat(2'b00, 0, 32'h7FFFFFF0, 32'h20);
        idle();
        chk("add_ovf_valid", out_valid, 1);
        chk("add_ovf_data", out_data, 32'h7FFFFFFF);
        chk("add_ovf_sat", out_sat, 1);
        chk("add_ovf_sticky", ovf_sticky, 1);

        beat(2'b01, 0, 32'h80000000, 32'd1);
        beat(2'b01, 0, 32'd5, 32'd7);
        chk("sub_unf_data", out_data, 32'h80000000);
        chk("sub_unf_sat", out_sat, 1);
        idle();
        chk("sub_data", out_data, 32'hFFFFFFFE);
        chk("sub_sat", out_sat, 0);

        beat(2'b11, 1, 32'd5, '0);
        beat(2'b10, 1, 32'd10, '0);
        chk("acc_ld", out_data, 32'd5);
        chk("acc_ld_ch", out_ch, 1);
        beat(2'b10, 1, 32'hFFFFFFEC, '0);
        chk("acc_add", out_data, 32'd15);
        idle();
        chk("acc_neg", out_data, 32'hFFFFFFFB);
        chk("acc_neg_ch", out_ch, 1);
        beat(2'b10, 0, '0, '0);
        beat(2'b10, 2, '0, '0);
        beat(2'b10, 3, '0, 32'h1234);
        idle();
        idle();
        chk("acc3_zero", out_data, 0);

        beat(2'b11, 2, 32'h7FFFFFFF, '0);
        beat(2'b10, 2, 32'd1, '0);
        chk("clamp_ld", out_data, 32'h7FFFFFFF);
        chk("clamp_ld_sat", out_sat, 0);
        beat(2'b10, 2, 32'hFFFFFFFF, '0);
        chk("clamp_hi", out_data, 32'h7FFFFFFF);
        chk("clamp_hi_sat", out_sat, 1);
        idle();
        chk("clamp_dec", out_data, 32'h7FFFFFFE);
        chk("clamp_dec_sat", out_sat, 0);
        idle();
        idle();

        cyc = 0;
        saw_stall = 0;
        for (int i = 0; i < 4; i++) begin
            tries = 0;
            acc = 0;
            while (!acc && tries < 20) begin
                step(1, 2'b00, 0, 32'(i * 100 + 1), 32'(i), cyc >= 3, 0, 0, acc);
                if (!acc) saw_stall = 1;
                cyc++;
                tries++;
            end
            if (!acc) chk("send_timeout", 0, 1);
        end
        chk("bp_stall_seen", saw_stall, 1);
        repeat (4) idle();
        chk("bp_drained", q.size(), 0);

        idle(1);
        chk("ovf_cleared", ovf_sticky, 0);
        beat(2'b00, 0, 32'h7FFFFFFF, 32'd1);
        idle(1);
        chk("ovf_set_wins", ovf_sticky, 1);
        idle(1);
        chk("ovf_clear2", ovf_sticky, 0);

        beat(2'b00, 0, 32'd1, 32'd2);
        beat(2'b00, 0, 32'd3, 32'd4);
        step(0, 2'd0, '0, '0, '0, 1, 0, 1, dummy);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_sat", out_sat, 0);
        for (int i = 0; i < CH; i++) beat(2'b10, CH_W'(i), '0, '0);
        idle();
        idle();
        chk("rst_acc_zero", out_data, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom), CH_W'($urandom),
                 rnd_val(), rnd_val(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, 0, dummy);
        end
        tries = 0;
        while ((q.size() != 0 || out_valid) && tries < 20) begin
            idle();
            tries++;
        end
        chk("final_queue_empty", q.size(), 0);
        chk("final_out_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
